// File: rtl/ram_8bit_pkg.sv
// Shared sizing defaults and word type for the ram_8bit FIFO-style buffer.
package ram_8bit_pkg;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/ram_8bit_mem.sv
// Storage array: one write port, one registered read port, cleared by sync reset.
module ram_8bit_mem
    import ram_8bit_pkg::*;
#(
    parameter int DATA_W = ram_8bit_pkg::DATA_W,
    parameter int DEPTH  = ram_8bit_pkg::DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Non-blocking update gives read-before-write when both ports hit one slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/ram_8bit.sv
// Pointer-addressed buffer: occupancy tracking and accept logic around ram_8bit_mem.
module ram_8bit
    import ram_8bit_pkg::*;
#(
    parameter int DATA_W = ram_8bit_pkg::DATA_W,
    parameter int DEPTH  = ram_8bit_pkg::DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_co,
    input  logic              rd_co,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] out
);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              wr_acc;
    logic              rd_acc;

    assign empty  = (count == '0);
    assign full   = (count == (ADDR_W+1)'(DEPTH));
    assign rd_acc = rd_co && !rst && !empty;
    // A full buffer still takes a write when a read frees the slot this cycle.
    assign wr_acc = wr_co && !rst && (!full || rd_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    ram_8bit_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (out)
    );

endmodule

// File: tb/tb_ram_8bit.sv
// Scoreboard bench for ram_8bit: queue model of stored words, expected reads queued at issue.
module tb_ram_8bit;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_co = 1'b0;
    logic       rd_co = 1'b0;
    logic [7:0] data = 8'h00;
    logic [7:0] out;

    logic [7:0] model_q[$];
    logic [7:0] sb_q[$];
    logic [7:0] last_out = 8'h00;
    int         n_vec = 0;
    int         n_err = 0;

    ram_8bit dut (
        .clk   (clk),
        .rst   (rst),
        .wr_co (wr_co),
        .rd_co (rd_co),
        .data  (data),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic rs);
        logic ra;
        logic wa;
        @(negedge clk);
        wr_co = w;
        rd_co = r;
        data  = d;
        rst   = rs;
        ra = r && !rs && (model_q.size() > 0);
        wa = w && !rs && ((model_q.size() < DEPTH) || ra);
        if (rs) begin
            model_q.delete();
            sb_q.delete();
        end
        if (ra) sb_q.push_back(model_q.pop_front());
        if (wa) model_q.push_back(d);
        @(posedge clk);
        #1;
        if (rs) last_out = 8'h00;
        else if (ra) last_out = sb_q.pop_front();
        chk("out", 32'(out), 32'(last_out));
        chk("count", 32'(dut.count), 32'(model_q.size()));
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        do_reset();
        chk("rst_out", 32'(out), 32'h0);

        // three writes then three reads
        step(1, 0, 8'h11, 0);
        step(1, 0, 8'h22, 0);
        step(1, 0, 8'h33, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0);
        chk("seq3_last", 32'(out), 32'h33);

        // fill, overflow drop, drain, underflow hold
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 8'hA0 + 8'(i), 0);
        step(1, 0, 8'hFF, 0);
        chk("full_drop_count", 32'(dut.count), 32'd8);
        for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        chk("underflow_hold", 32'(out), 32'hA7);

        // simultaneous read/write while empty: write only
        do_reset();
        step(1, 1, 8'h5A, 0);
        chk("empty_rw_out", 32'(out), 32'h0);
        chk("empty_rw_count", 32'(dut.count), 32'd1);
        step(0, 1, 8'h00, 0);
        chk("empty_rw_read", 32'(out), 32'h5A);

        // simultaneous read/write while full: read-before-write
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 8'hA0 + 8'(i), 0);
        step(1, 1, 8'hC3, 0);
        chk("full_rw_out", 32'(out), 32'hA0);
        for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0);
        chk("full_rw_last", 32'(out), 32'hC3);

        // reset mid-sequence dominates a read
        do_reset();
        step(1, 0, 8'h01, 0);
        step(1, 0, 8'h02, 0);
        step(1, 0, 8'h03, 0);
        step(0, 1, 8'h00, 1);
        chk("rst_rd_out", 32'(out), 32'h0);
        for (int i = 0; i < DEPTH; i++) chk("rst_mem_clear", 32'(dut.u_mem.mem[i]), 32'h0);
        step(0, 1, 8'h00, 0);
        chk("rst_then_rd", 32'(out), 32'h0);

        // random traffic with an occasional reset
        do_reset();
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 49) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
